// File: rtl/axi_mmio_console.sv
// AXI4 MMIO responder: TX byte, status, scratch and beat counter.
// Console bytes leave on a valid/ready stream.
module axi_mmio_console #(
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [63:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic        up;
  logic [11:0] w_off, r_off, r_next_off;
  logic [7:0]  r_len, r_idx;
  logic        w_sticky;
  logic [63:0] scratch;
  logic [31:0] beatcnt;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        w_err, tx_load;
  logic [64:0] r_val;
  logic        unused_ok;

  // Returns {error, data} for one aligned 8-byte slot.
  function automatic logic [64:0] reg_read(
    input logic [11:0] off,
    input logic [63:0] scr,
    input logic [31:0] cnt,
    input logic        txv
  );
    logic [64:0] v;
    case (off)
      12'h000: v = 65'd0;
      12'h008: v = {1'b0, 63'd0, txv};
      12'h010: v = {1'b0, scr};
      12'h018: v = {1'b0, 32'd0, cnt};
      default: v = {1'b1, 64'd0};
    endcase
    return v;
  endfunction

  assign w_err   = (w_off >= 12'h020) || (w_off[2:0] != 3'd0);
  assign tx_load = (w_off == 12'h000) && s_axi_wstrb[0];

  assign s_axi_awready = up && (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA) && !(tx_load && tx_valid);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bresp   = {s_axi_bvalid && w_sticky, 1'b0};
  assign s_axi_arready = up && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign b_hs  = s_axi_bvalid && s_axi_bready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;

  assign r_next_off = ar_hs ? s_axi_araddr[11:0] : r_off + 12'd8;
  assign r_val = reg_read(r_next_off, scratch, beatcnt, tx_valid);

  assign unused_ok = ^{s_axi_awaddr[ADDR_WIDTH-1:12],
                       s_axi_araddr[ADDR_WIDTH-1:12], s_axi_awlen};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      up      <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      up      <= 1'b1;
    end
  end

  always_comb begin
    w_next = w_state;
    r_next = r_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && s_axi_wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (r_hs && s_axi_rlast) r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_axi_bid <= '0;
      w_off     <= '0;
      w_sticky  <= 1'b0;
      scratch   <= '0;
      beatcnt   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
    end else begin
      if (aw_hs) begin
        s_axi_bid <= s_axi_awid;
        w_off     <= s_axi_awaddr[11:0];
        w_sticky  <= 1'b0;
      end
      if (w_hs) begin
        w_off    <= w_off + 12'd8;
        beatcnt  <= beatcnt + 32'd1;
        w_sticky <= w_sticky | w_err;
        if (w_off == 12'h010) begin
          for (int i = 0; i < 8; i++)
            if (s_axi_wstrb[i]) scratch[8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
        if (tx_load) tx_data <= s_axi_wdata[7:0];
      end
      // A load only happens with tx_valid low, so set and clear never collide.
      if (w_hs && tx_load) tx_valid <= 1'b1;
      else if (tx_valid && tx_ready) tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
      s_axi_rlast <= 1'b0;
      r_off       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
    end else if (ar_hs) begin
      s_axi_rid   <= s_axi_arid;
      r_off       <= r_next_off;
      r_len       <= s_axi_arlen;
      r_idx       <= 8'd0;
      s_axi_rdata <= r_val[63:0];
      s_axi_rresp <= {r_val[64], 1'b0};
      s_axi_rlast <= (s_axi_arlen == 8'd0);
    end else if (r_hs) begin
      if (s_axi_rlast) begin
        s_axi_rlast <= 1'b0;
      end else begin
        r_off       <= r_next_off;
        r_idx       <= r_idx + 8'd1;
        s_axi_rdata <= r_val[63:0];
        s_axi_rresp <= {r_val[64], 1'b0};
        s_axi_rlast <= (r_idx + 8'd1 == r_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_mmio_console.sv
// Self-checking bench for axi_mmio_console.
// Vector table, hand sequences and random traffic against a register model.
module tb_axi_mmio_console;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [63:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic        s_axi_awvalid, s_axi_awready;
  logic [63:0] s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic        s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  axi_mmio_console #(.ID_WIDTH(5), .ADDR_WIDTH(64)) dut (
    .clock(clock), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Register model
  logic [63:0] mscr;
  logic [31:0] mbc;
  logic        mtxv;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  logic [63:0] wbuf[8];
  logic [7:0]  sbuf[8];
  logic [63:0] rbuf[8];
  logic [1:0]  rrbuf[8];

  typedef struct {
    logic [11:0] off;
    logic [63:0] wd;
    logic [7:0]  st;
    logic [1:0]  br;
    logic [63:0] rd;
    logic [1:0]  rr;
  } vec_t;
  vec_t tv[7];

  always @(posedge clock)
    if (!reset && tx_valid && tx_ready) got_q.push_back(tx_data);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic m_err(input logic [11:0] o);
    return (o >= 12'h020) || (o[2:0] != 3'd0);
  endfunction

  function automatic logic [63:0] m_rd(input logic [11:0] o);
    if (m_err(o)) return 64'd0;
    if (o == 12'h008) return {63'd0, mtxv};
    if (o == 12'h010) return mscr;
    if (o == 12'h018) return {32'd0, mbc};
    return 64'd0;
  endfunction

  task automatic m_apply(input logic [11:0] o, input logic [63:0] d,
                         input logic [7:0] s);
    mbc = mbc + 32'd1;
    if (!m_err(o)) begin
      if (o == 12'h000 && s[0]) begin
        exp_q.push_back(d[7:0]);
        mtxv = 1'b1;
      end
      if (o == 12'h010)
        for (int i = 0; i < 8; i++)
          if (s[i]) mscr[8*i +: 8] = d[8*i +: 8];
    end
  endtask

  function automatic logic sig(input int ch);
    case (ch)
      0: return s_axi_awready;
      1: return s_axi_wready;
      2: return s_axi_arready;
      3: return s_axi_bvalid;
      default: return s_axi_rvalid;
    endcase
  endfunction

  // Called at a negedge; returns just after the negedge where sig(ch) is high.
  task automatic wait_for(input int ch, input string nm);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (sig(ch)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=none expected=handshake", nm);
    end
  endtask

  task automatic drive_idle();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_rready = 0; s_axi_wlast = 0;
  endtask

  task automatic m_reset();
    mscr = 0; mbc = 0; mtxv = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    drive_idle();
    m_reset();
    repeat (2) @(negedge clock);
    reset = 0;
    @(negedge clock);
  endtask

  task automatic aw_phase(input logic [11:0] off, input logic [7:0] len,
                          input logic [4:0] id);
    s_axi_awaddr = {$urandom(), $urandom()};
    s_axi_awaddr[11:0] = off;
    s_axi_awid = id;
    s_axi_awlen = len;
    s_axi_awvalid = 1;
    wait_for(0, "aw");
    @(negedge clock);
    s_axi_awvalid = 0;
  endtask

  task automatic w_beat(input logic [11:0] o, input logic [63:0] d,
                        input logic [7:0] s, input bit last);
    s_axi_wdata = d;
    s_axi_wstrb = s;
    s_axi_wlast = last;
    s_axi_wvalid = 1;
    wait_for(1, "w");
    m_apply(o, d, s);
    @(negedge clock);
    s_axi_wvalid = 0;
    s_axi_wlast = 0;
  endtask

  task automatic b_phase(output logic [1:0] resp, output logic [4:0] id);
    s_axi_bready = 1;
    wait_for(3, "b");
    resp = s_axi_bresp;
    id = s_axi_bid;
    @(negedge clock);
    s_axi_bready = 0;
  endtask

  task automatic axi_write(input logic [11:0] off, input logic [7:0] len,
                           input logic [4:0] id, input bit mcheck,
                           output logic [1:0] resp);
    logic [1:0]  eb = 2'b00;
    logic [4:0]  bid;
    logic [11:0] o;
    aw_phase(off, len, id);
    for (int b = 0; b <= int'(len); b++) begin
      o = off + 12'(8 * b);
      if (m_err(o)) eb = 2'b10;
      w_beat(o, wbuf[b], sbuf[b], b == int'(len));
    end
    b_phase(resp, bid);
    chk("bid", 64'(bid), 64'(id));
    if (mcheck) chk("bresp", 64'(resp), 64'(eb));
  endtask

  task automatic axi_read(input logic [11:0] off, input logic [7:0] len,
                          input logic [4:0] id, input bit mcheck);
    logic [11:0] o;
    s_axi_araddr = {$urandom(), $urandom()};
    s_axi_araddr[11:0] = off;
    s_axi_arid = id;
    s_axi_arlen = len;
    s_axi_arvalid = 1;
    wait_for(2, "ar");
    @(negedge clock);
    s_axi_arvalid = 0;
    chk("r_latency", 64'(s_axi_rvalid), 64'd1);
    s_axi_rready = 1;
    for (int b = 0; b <= int'(len); b++) begin
      o = off + 12'(8 * b);
      wait_for(4, "r");
      rbuf[b] = s_axi_rdata;
      rrbuf[b] = s_axi_rresp;
      chk("rlast", 64'(s_axi_rlast), 64'(b == int'(len)));
      chk("rid", 64'(s_axi_rid), 64'(id));
      if (mcheck) begin
        chk("rdata", s_axi_rdata, m_rd(o));
        chk("rresp", 64'(s_axi_rresp), m_err(o) ? 64'd2 : 64'd0);
      end
      @(negedge clock);
    end
    s_axi_rready = 0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [4:0]  bid;
    logic [11:0] off;
    logic [7:0]  len;
    int          r;

    tv[0] = '{12'h010, 64'h1122334455667788, 8'hFF, 2'b00,
              64'h1122334455667788, 2'b00};
    tv[1] = '{12'h010, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 2'b00,
              64'h11223344FFFFFFFF, 2'b00};
    tv[2] = '{12'h020, 64'h00000000DEADBEEF, 8'hFF, 2'b10, 64'd0, 2'b10};
    tv[3] = '{12'h014, 64'h0123456789ABCDEF, 8'hFF, 2'b10, 64'd0, 2'b10};
    tv[4] = '{12'h010, 64'h5555555555555555, 8'h00, 2'b00,
              64'h11223344FFFFFFFF, 2'b00};
    tv[5] = '{12'h008, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b00, 64'd0, 2'b00};
    tv[6] = '{12'h010, 64'hAA00000000000000, 8'h80, 2'b00,
              64'hAA223344FFFFFFFF, 2'b00};

    reset = 1;
    tx_ready = 1;
    drive_idle();
    s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0;
    s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0;
    m_reset();

    #12;
    chk("rst_ready", 64'({s_axi_awready, s_axi_arready, s_axi_wready}), 64'd0);
    chk("rst_valid", 64'({s_axi_bvalid, s_axi_rvalid, s_axi_rlast, tx_valid}),
        64'd0);
    chk("rst_data", s_axi_rdata, 64'd0);
    chk("rst_misc", 64'({s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid,
                         tx_data}), 64'd0);
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1 chk("rel_ready", 64'({s_axi_awready, s_axi_arready}), 64'd3);
    @(negedge clock);

    axi_read(12'h010, 0, 5'h01, 0);
    chk("rst_scratch", rbuf[0], 64'd0);
    axi_read(12'h018, 0, 5'h02, 0);
    chk("rst_beatcnt", rbuf[0], 64'd0);

    for (int i = 0; i < 7; i++) begin
      wbuf[0] = tv[i].wd;
      sbuf[0] = tv[i].st;
      axi_write(tv[i].off, 0, 5'(i), 0, resp);
      chk($sformatf("tbl%0d_bresp", i), 64'(resp), 64'(tv[i].br));
      axi_read(tv[i].off, 0, 5'(i + 8), 0);
      chk($sformatf("tbl%0d_rdata", i), rbuf[0], tv[i].rd);
      chk($sformatf("tbl%0d_rresp", i), 64'(rrbuf[0]), 64'(tv[i].rr));
    end
    axi_read(12'h018, 0, 5'h03, 0);
    chk("beatcnt_after_tbl", rbuf[0], 64'd7);

    // Console backpressure
    tx_ready = 0;
    wbuf[0] = 64'h41; sbuf[0] = 8'h01;
    axi_write(12'h000, 0, 5'h04, 1, resp);
    chk("tx_valid_41", 64'(tx_valid), 64'd1);
    chk("tx_data_41", 64'(tx_data), 64'h41);
    axi_read(12'h008, 0, 5'h05, 1);
    chk("status_pending", rbuf[0], 64'd1);
    aw_phase(12'h000, 0, 5'h06);
    s_axi_wdata = 64'h42; s_axi_wstrb = 8'h01;
    s_axi_wlast = 1; s_axi_wvalid = 1;
    repeat (3) begin
      #1 chk("tx_backpressure", 64'(s_axi_wready), 64'd0);
      @(negedge clock);
    end
    tx_ready = 1;
    @(negedge clock);
    tx_ready = 0;
    w_beat(12'h000, 64'h42, 8'h01, 1);
    b_phase(resp, bid);
    chk("tx2_bresp", 64'(resp), 64'd0);
    chk("tx2_bid", 64'(bid), 64'h06);
    chk("tx_data_42", 64'(tx_data), 64'h42);
    tx_ready = 1;
    repeat (3) @(negedge clock);
    mtxv = 0;

    // Burst read across the whole map after 3 beats
    do_reset();
    tx_ready = 0;
    wbuf[0] = 64'h55; sbuf[0] = 8'h01;
    axi_write(12'h000, 0, 5'h07, 1, resp);
    wbuf[0] = 64'h0BADF00D0BADF00D; sbuf[0] = 8'hFF;
    axi_write(12'h010, 0, 5'h08, 1, resp);
    wbuf[0] = 64'hCAFE00000000BEEF; sbuf[0] = 8'hFF;
    axi_write(12'h010, 0, 5'h09, 1, resp);
    axi_read(12'h000, 3, 5'h13, 1);
    chk("burst_b0", rbuf[0], 64'd0);
    chk("burst_b1", rbuf[1], 64'd1);
    chk("burst_b2", rbuf[2], 64'hCAFE00000000BEEF);
    chk("burst_b3", rbuf[3], 64'd3);
    tx_ready = 1;
    repeat (3) @(negedge clock);
    mtxv = 0;

    // Offset wraps from 0xFF8 to TXDATA; sticky error persists
    wbuf[0] = 64'h77; sbuf[0] = 8'hFF;
    wbuf[1] = 64'h66; sbuf[1] = 8'hFF;
    axi_write(12'hFF8, 1, 5'h0A, 1, resp);
    chk("wrap_bresp", 64'(resp), 64'd2);
    repeat (3) @(negedge clock);
    mtxv = 0;

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) off = 12'(8 * r);
      else if (r < 8) off = 12'($urandom_range(0, 4095));
      else off = 12'hFF0;
      len = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 8; b++) begin
          wbuf[b] = {$urandom(), $urandom()};
          sbuf[b] = 8'($urandom());
        end
        axi_write(off, len, 5'($urandom()), 1, resp);
        repeat (3) @(negedge clock);
        mtxv = 0;
      end else begin
        axi_read(off, len, 5'($urandom()), 1);
      end
    end

    // Reset in the middle of a long read burst
    s_axi_araddr = 64'h10;
    s_axi_arid = 5'h1F;
    s_axi_arlen = 8'd7;
    s_axi_arvalid = 1;
    wait_for(2, "ar_mid");
    @(negedge clock);
    s_axi_arvalid = 0;
    s_axi_rready = 1;
    wait_for(4, "r_mid");
    @(negedge clock);
    #1 chk("mid_rvalid_before", 64'(s_axi_rvalid), 64'd1);
    reset = 1;
    #1 chk("mid_rvalid_reset", 64'(s_axi_rvalid), 64'd0);
    s_axi_rready = 0;
    m_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1 chk("mid_arready_rel", 64'({s_axi_arready, s_axi_awready}), 64'd3);
    @(negedge clock);
    axi_read(12'h010, 1, 5'h0C, 1);

    repeat (3) @(negedge clock);
    chk("tx_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("tx_byte%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
